// File: rtl/capture_trigger_pkg.sv
// Shared definitions for the logic analyzer capture path: state encodings and sample width.
// The readout and control blocks import the same encodings.
package capture_trigger_pkg;

  localparam int LA_SAMPLE_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } cap_state_e;

endpackage

// File: rtl/capture_trigger_trig_match.sv
// Masked pattern comparator: a mask bit of 1 means the bit is compared, 0 means don't care.
module capture_trigger_trig_match #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] sample,
  input  logic [WIDTH-1:0] value,
  input  logic [WIDTH-1:0] mask,
  output logic             match
);

  assign match = (((sample ^ value) & mask) == '0);

endmodule

// File: rtl/capture_trigger.sv
// Circular-buffer capture FSM: writes samples to an external RAM, triggers, then stores post-trigger samples.
// Optional edge-qualified trigger when CAPTURE_TRIG_EDGE_EN is defined (adds the trig_edge input).
module capture_trigger
  import capture_trigger_pkg::*;
#(
  parameter  int WIDTH  = LA_SAMPLE_W,
  parameter  int DEPTH  = 1024,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  sample_in,
  input  logic              sample_en,
  input  logic              arm,
  input  logic              force_trig,
  input  logic [WIDTH-1:0]  trig_value,
  input  logic [WIDTH-1:0]  trig_mask,
`ifdef CAPTURE_TRIG_EDGE_EN
  input  logic              trig_edge,
`endif
  input  logic [ADDR_W-1:0] post_trig,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WIDTH-1:0]  wr_data,
  output logic [ADDR_W-1:0] trig_addr,
  output logic              wrapped,
  output logic              busy,
  output logic              done
);

  cap_state_e        state_q, state_d;
  logic [WIDTH-1:0]  trig_value_q, trig_mask_q;
  logic [ADDR_W-1:0] post_trig_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              match;
  logic              qualified;
  logic              do_write;
  logic              hit;

  capture_trigger_trig_match #(.WIDTH(WIDTH)) u_match (
    .sample (sample_in),
    .value  (trig_value_q),
    .mask   (trig_mask_q),
    .match  (match)
  );

`ifdef CAPTURE_TRIG_EDGE_EN
  logic trig_edge_q;
  logic prev_match_q;
  assign qualified = match & (~trig_edge_q | ~prev_match_q);
`else
  assign qualified = match;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // arm takes priority over everything in the same cycle, so no sample is written on an arm cycle
  always_comb begin
    state_d  = state_q;
    do_write = 1'b0;
    hit      = 1'b0;
    if (arm) begin
      state_d = ST_ARMED;
    end else begin
      case (state_q)
        ST_ARMED: begin
          if (sample_en) begin
            do_write = 1'b1;
            if (qualified | force_trig) begin
              hit     = 1'b1;
              state_d = (post_trig_q == '0) ? ST_DONE : ST_POST;
            end
          end
        end
        ST_POST: begin
          if (sample_en) begin
            do_write = 1'b1;
            if (cnt_q == ADDR_W'(1)) state_d = ST_DONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      trig_value_q <= '0;
      trig_mask_q  <= '0;
      post_trig_q  <= '0;
      ptr_q        <= '0;
      cnt_q        <= '0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      trig_addr    <= '0;
      wrapped      <= 1'b0;
`ifdef CAPTURE_TRIG_EDGE_EN
      trig_edge_q  <= 1'b0;
      prev_match_q <= 1'b0;
`endif
    end else if (arm) begin
      trig_value_q <= trig_value;
      trig_mask_q  <= trig_mask;
      post_trig_q  <= post_trig;
      ptr_q        <= '0;
      cnt_q        <= '0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wrapped      <= 1'b0;
`ifdef CAPTURE_TRIG_EDGE_EN
      // Start as if the previous sample matched, so the first armed sample cannot form an edge.
      trig_edge_q  <= trig_edge;
      prev_match_q <= 1'b1;
`endif
    end else begin
      wr_en <= do_write;
      if (do_write) begin
        wr_data <= sample_in;
        wr_addr <= ptr_q;
        ptr_q   <= ptr_q + 1'b1;
        if (ptr_q == '1) wrapped <= 1'b1;
`ifdef CAPTURE_TRIG_EDGE_EN
        prev_match_q <= match;
`endif
      end
      if (hit) begin
        trig_addr <= ptr_q;
        cnt_q     <= post_trig_q;
      end else if ((state_q == ST_POST) && do_write) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  assign busy = (state_q == ST_ARMED) || (state_q == ST_POST);
  assign done = (state_q == ST_DONE);

endmodule
